// File: rtl/seq_frame_ctrl.sv
// seq_frame_ctrl: serialises 3-bit frame words MSB-first on a free-running 3-phase
// stream, padding with 000 filler frames, and counts data frames and checker errors per run.
module seq_frame_ctrl (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [3:0] num_frames_i,
    input  logic       word_valid_i,
    input  logic [2:0] word_data_i,
    output logic       word_ready_o,
    output logic       din_o,
    output logic       chk_reset_n_o,
    input  logic       err_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [3:0] err_count_o,
    output logic [3:0] frame_count_o
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t     state_q;
    logic [1:0] phase_q;
    logic [2:0] frame_q;
    logic       data_q;
    logic [3:0] rem_q;
    logic [3:0] err_cnt_q;
    logic [3:0] frm_cnt_q;
    logic       p2;
    logic       hs;
    assign p2            = phase_q == 2'd2;
    assign word_ready_o  = p2 && state_q == RUN && rem_q != 4'd0;
    assign hs            = word_ready_o && word_valid_i;
    assign din_o         = phase_q == 2'd0 ? frame_q[2] : phase_q == 2'd1 ? frame_q[1] : frame_q[0];
    assign chk_reset_n_o = ~rst_i;
    assign busy_o        = state_q == RUN || state_q == DRAIN;
    assign done_o        = state_q == DONE;
    assign err_count_o   = err_cnt_q;
    assign frame_count_o = frm_cnt_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            phase_q   <= 2'd0;
            frame_q   <= 3'b000;
            data_q    <= 1'b0;
            rem_q     <= 4'd0;
            err_cnt_q <= 4'd0;
            frm_cnt_q <= 4'd0;
        end else begin
            phase_q <= p2 ? 2'd0 : phase_q + 2'd1;
            if (p2) begin
                frame_q <= hs ? word_data_i : 3'b000;
                data_q  <= hs;
                if (data_q) begin
                    frm_cnt_q <= frm_cnt_q + 4'd1;
                    if (err_i) err_cnt_q <= err_cnt_q + 4'd1;
                end
            end
            // The final data frame is counted at the same edge that moves DRAIN to DONE,
            // so nothing is still in flight by the time a new Start can clear the counters.
            case (state_q)
                IDLE: if (start_i) begin
                    rem_q     <= num_frames_i;
                    err_cnt_q <= 4'd0;
                    frm_cnt_q <= 4'd0;
                    state_q   <= num_frames_i != 4'd0 ? RUN : DONE;
                end
                RUN: if (hs) begin
                    rem_q <= rem_q - 4'd1;
                    if (rem_q == 4'd1) state_q <= DRAIN;
                end
                DRAIN: if (p2) state_q <= DONE;
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_frame_ctrl.sv
// tb_seq_frame_ctrl: directed scenarios plus random traffic against a slot-schedule reference model.
module tb_seq_frame_ctrl;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, wv = 1'b0, err = 1'b0;
    logic [3:0] num = 4'd0;
    logic [2:0] wd = 3'b000;
    logic ready, din, chk_n, busy, done;
    logic [3:0] ecnt, fcnt;

    always #5 clk = ~clk;

    seq_frame_ctrl dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .num_frames_i(num),
        .word_valid_i(wv), .word_data_i(wd), .word_ready_o(ready), .din_o(din),
        .chk_reset_n_o(chk_n), .err_i(err), .busy_o(busy), .done_o(done),
        .err_count_o(ecnt), .frame_count_o(fcnt)
    );

    int checks = 0, errors = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Model: cycle index since reset release; frame slot s occupies cycles 3s..3s+2.
    localparam int NEVER = 32'h7fffffff;
    int cyc, ts, n, acc, done_c, fc, ec, done_cyc, done_cnt;
    bit run_on;
    bit [2:0] sw[int];
    bit sd[int];
    bit dh[int];

    function automatic void mreset();
        cyc = 0; run_on = 0; ts = 0; n = 0; acc = 0; done_c = -1; fc = 0; ec = 0;
        sw.delete(); sd.delete(); dh.delete();
    endfunction

    task automatic tick();
        int ph = cyc % 3;
        int s = cyc / 3;
        bit idle = !run_on || cyc > done_c;
        bit er = run_on && cyc > ts && ph == 2 && acc < n;
        bit [2:0] w = sw.exists(s) ? sw[s] : 3'b000;
        bit dflag = sd.exists(s) && sd[s];
        @(negedge clk);
        chk("ready", ready, er);
        chk("din", din, w[2-ph]);
        chk("busy", busy, run_on && cyc > ts && cyc < done_c);
        chk("done", done, cyc == done_c);
        chk("frame_count", fcnt, fc);
        chk("err_count", ecnt, ec);
        chk("chk_reset_n", chk_n, 1);
        dh[cyc] = din;
        if (done) begin done_cyc = cyc; done_cnt++; end
        if (ph == 2 && dflag) begin fc++; if (err) ec++; end
        if (er && wv) begin
            sw[s+1] = wd; sd[s+1] = 1; acc++;
            if (acc == n) done_c = 3 * s + 6;
        end
        if (idle && start) begin
            run_on = 1; ts = cyc; n = num; acc = 0; fc = 0; ec = 0;
            done_c = num == 4'd0 ? cyc + 1 : NEVER;
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic align();
        while (cyc % 3 != 0) tick();
    endtask

    function automatic logic [8:0] din_bits(input int t0);
        logic [8:0] v = '0;
        for (int i = 0; i < 9; i++) v[8-i] = dh.exists(t0 + i) ? dh[t0+i] : 1'bx;
        return v;
    endfunction

    int t;
    bit [2:0] wl[3] = '{3'b111, 3'b110, 3'b111};

    initial begin
        #2;
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_ready", ready, 0);
        chk("rst_din", din, 0); chk("rst_fcnt", fcnt, 0); chk("rst_ecnt", ecnt, 0);
        chk("rst_chk_n", chk_n, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mreset();

        // Idle stream with ERR stuck high
        err = 1'b1;
        repeat (30) tick();
        chk("idle_fcnt", fcnt, 0); chk("idle_ecnt", ecnt, 0);
        err = 1'b0;

        // Three gapless frames, checker flags frames 1 and 3
        align();
        t = cyc; start = 1; num = 4'd3; wv = 1; wd = wl[0];
        tick();
        start = 0;
        repeat (13) begin
            wd = wl[acc < 3 ? acc : 0];
            err = (cyc == t + 5 || cyc == t + 11);
            tick();
        end
        err = 0; wv = 0;
        chk("r34_din", din_bits(t + 3), 9'b111110111);
        chk("r34_done_cyc", done_cyc - t, 12);
        chk("r34_ecnt", ecnt, 2); chk("r34_fcnt", fcnt, 3);

        // Two frames with one source gap
        align();
        t = cyc; start = 1; num = 4'd2; wv = 1; wd = 3'b101;
        tick();
        start = 0;
        repeat (15) begin wv = (cyc != t + 2); tick(); end
        wv = 0;
        chk("r35_din", din_bits(t + 3), 9'b000101101);
        chk("r35_done_cyc", done_cyc - t, 12);
        chk("r35_fcnt", fcnt, 2);

        // Zero-frame run
        t = cyc; start = 1; num = 4'd0;
        tick();
        start = 0;
        repeat (3) tick();
        chk("r36_done_cyc", done_cyc - t, 1);
        chk("r36_fcnt", fcnt, 0); chk("r36_ecnt", ecnt, 0);

        // Start while busy and in the Done cycle
        align();
        t = cyc; start = 1; num = 4'd4; wv = 1; wd = 3'b011;
        tick();
        done_cnt = 0;
        num = 4'd9;
        repeat (20) begin start = (cyc == t + 4 || cyc == t + 15); tick(); end
        start = 0; wv = 0;
        chk("r37_done_cnt", done_cnt, 1);
        chk("r37_done_cyc", done_cyc - t, 15);
        chk("r37_fcnt", fcnt, 4);

        // Reset during DRAIN
        align();
        t = cyc; start = 1; num = 4'd2; wv = 1; wd = 3'b111; err = 1;
        tick();
        start = 0;
        while (cyc < t + 7) tick();
        chk("r38_busy_before", busy, 1);
        rst = 1'b1;
        #2;
        chk("r38_busy", busy, 0); chk("r38_done", done, 0); chk("r38_ready", ready, 0);
        chk("r38_din", din, 0); chk("r38_fcnt", fcnt, 0); chk("r38_ecnt", ecnt, 0);
        chk("r38_chk_n", chk_n, 0);
        repeat (4) begin
            @(negedge clk);
            chk("r38_no_done", done, 0); chk("r38_chk_n_hold", chk_n, 0);
        end
        @(posedge clk); #1 rst = 1'b0;
        mreset();
        wv = 0; err = 0;

        // Random traffic
        repeat (2500) begin
            start = $urandom_range(7) == 0;
            num = $urandom_range(1) ? 4'($urandom_range(3)) : 4'($urandom_range(15));
            wv = $urandom_range(3) != 0;
            wd = 3'($urandom);
            err = 1'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_frame_ctrl.md
SEQ_FRAME_CTRL -- requirements
Module: seq_frame_ctrl

Interface
REQ-001 Clock  input  1  sole clock; all state updates on rising edge.
REQ-002 Reset  input  1  asynchronous, active-high; forces reset state immediately, independent of Clock.
REQ-003 Start  input  1  run request; sampled only in IDLE.
REQ-004 NumFrames  input  4  data frames in the run (0-15); latched when Start is accepted.
REQ-005 WordValid  input  1  source holds a valid 3-bit frame word.
REQ-006 WordData  input  3  frame word; bit 2 is sent first, bit 0 last.
REQ-007 WordReady  output  1  word accepted this cycle when WordValid=1.
REQ-008 Din  output  1  serial bit stream to the downstream 3-bit frame checker.
REQ-009 ChkReset_n  output  1  checker reset, active-low; equals NOT Reset, combinational.
REQ-010 ERR  input  1  checker flag; valid in the cycle the third bit of a frame is driven.
REQ-011 Busy  output  1  run in progress.
REQ-012 Done  output  1  one-cycle pulse at run completion.
REQ-013 ErrCount  output  4  data frames flagged by ERR in the current or last run.
REQ-014 FrameCount  output  4  data frames completed in the current or last run.

Function
REQ-015 Phase counter SHALL free-run 0,1,2,0,... from reset release, one step per cycle, independent of run state.
REQ-016 Din SHALL equal frame_reg[2-phase]; frame_reg loads at the edge ending every phase-2 cycle.
REQ-017 Loaded value: accepted WordData if a handshake occurred that cycle, else filler 3'b000.
REQ-018 Stream SHALL never pause; filler frames keep the checker frame-aligned during idle and source gaps.
REQ-019 A data-frame flag SHALL accompany frame_reg; filler frames are never counted.
REQ-020 WordReady SHALL be 1 only in phase-2 cycles while state=RUN and remaining>0.
REQ-021 States: IDLE, RUN, DRAIN, DONE.
REQ-022 IDLE: Start=1 -> latch NumFrames into remaining; clear ErrCount and FrameCount; go RUN if NumFrames>0, else DONE.
REQ-023 RUN: each handshake decrements remaining; handshake taking remaining 1->0 -> DRAIN.
REQ-024 DRAIN: at the edge ending phase 2 of the final data frame -> DONE.
REQ-025 DONE: Done=1 for exactly one cycle -> IDLE.
REQ-026 Busy=1 in RUN and DRAIN only; Start is ignored outside IDLE, including in DONE.
REQ-027 At each phase-2 edge with the data flag set: FrameCount+1; if ERR=1 also ErrCount+1.
REQ-028 Counters SHALL hold between runs and reset to 0 only on Reset or accepted Start.
REQ-029 Source gaps: WordValid=0 at a ready slot inserts one filler frame; remaining is unchanged.
REQ-030 Latency: Start accepted in a phase-0 cycle t -> first WordReady at t+2; back-to-back words at t+2, t+5, t+8, ...

Reset
REQ-031 On Reset: state IDLE, phase 0, frame_reg 000, data flag 0, remaining 0, Din 0, WordReady 0, Busy 0, Done 0, ErrCount 0, FrameCount 0.
REQ-032 Reset mid-run SHALL abort the run with no Done pulse and clear all counters.
REQ-033 ChkReset_n SHALL hold the checker in reset while Reset=1, so both restart aligned at phase 0.

Verification
REQ-034 Start at phase-0 cycle t, NumFrames=3, words 111,110,111 always valid -> Din 1,1,1,1,1,0,1,1,1 in t+3..t+11; Done at t+12; ErrCount=2; FrameCount=3.
REQ-035 NumFrames=2 with WordValid=0 for one ready slot -> one 000 filler frame between data frames; FrameCount=2; Done three cycles later than the gapless run.
REQ-036 NumFrames=0 -> Done pulse the cycle after Start; Busy never 1; both counters read 0.
REQ-037 Start pulsed while Busy=1, and again in the Done cycle -> both ignored; remaining and counters unaffected.
REQ-038 Reset asserted mid-DRAIN -> all outputs take their reset values immediately; no Done pulse; ChkReset_n=0 while Reset=1.
REQ-039 Idle for 30 cycles after Reset with ERR forced to 1 -> Din stays 0; ErrCount and FrameCount stay 0.
